// File: rtl/pipeline_stall_ctrl.sv
// Pipeline interlock: load-use stall, MDU occupancy sequencing, branch flush,
// and a saturating stall-cycle counter for performance debug.
module pipeline_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             ID_mdu_start,
    input  logic             ID_mdu_div,
    input  logic             ID_reads_hilo,
    input  logic             ID_EX_MEMRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_branch_taken,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             mdu_issue,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       lu, md, stall, flush;

    always_comb begin
        lu = ID_EX_MEMRead && (ID_EX_rt != 5'd0) &&
             ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
        // MDU outputs are forced idle while reset is held
        mdu_busy  = !rst && (state_q == RUN);
        mdu_done  = mdu_busy && (cnt_q == 6'd1);
        // Dependants wait through the done cycle too; HI/LO lands at its end
        md        = mdu_busy && (ID_reads_hilo || ID_mdu_start);
        flush     = !rst && EX_branch_taken;
        stall     = !rst && (lu || md) && !EX_branch_taken;
        mdu_issue = !rst && ID_mdu_start && !stall && !flush;

        PC_write     = !stall;
        IF_ID_write  = !stall;
        IF_ID_flush  = flush;
        ID_EX_bubble = stall || flush;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_issue) begin
                    state_d = RUN;
                    cnt_d   = ID_mdu_div ? DIV_N : MULT_N;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: load-use, MDU sequencing, flush
// priority, reset abort and counter saturation with hand-computed expectations.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic        IF_ID_uses_rt, ID_mdu_start, ID_mdu_div, ID_reads_hilo;
    logic        ID_EX_MEMRead, EX_branch_taken;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
    logic        mdu_issue, mdu_busy, mdu_done;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .ID_mdu_start(ID_mdu_start), .ID_mdu_div(ID_mdu_div), .ID_reads_hilo(ID_reads_hilo),
        .ID_EX_MEMRead(ID_EX_MEMRead), .ID_EX_rt(ID_EX_rt), .EX_branch_taken(EX_branch_taken),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .mdu_issue(mdu_issue), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle_in();
        IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_uses_rt = 1'b0;
        ID_mdu_start = 1'b0; ID_mdu_div = 1'b0; ID_reads_hilo = 1'b0;
        ID_EX_MEMRead = 1'b0; ID_EX_rt = 5'd0; EX_branch_taken = 1'b0;
    endtask

    // inputs change 1 time unit after the rising edge, checks happen on the falling edge
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle_in(); nxt(); rst = 1'b0;
    endtask

    // decode group: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble}
    function automatic logic [31:0] dec();
        return {28'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble};
    endfunction

    int done_seen;

    initial begin
        rst = 1'b1; idle_in();
        nxt(); nxt();
        @(negedge clk);
        chk("reset_decode", dec(), 32'b1100);
        chk("reset_mdu", {mdu_issue, mdu_busy, mdu_done}, 3'b000);
        chk("reset_cnt", stall_cnt, 16'd0);
        nxt(); rst = 1'b0;

        // load-use on rs
        do_reset();
        ID_EX_MEMRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
        @(negedge clk); chk("lu_rs_stall", dec(), 32'b0001);
        nxt(); ID_EX_MEMRead = 1'b0;
        @(negedge clk); chk("lu_rs_release", dec(), 32'b1100);
        chk("lu_rs_cnt", stall_cnt, 16'd1);

        // rt masking and r0 exclusion
        nxt(); idle_in();
        ID_EX_MEMRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rt = 5'd8; IF_ID_rs = 5'd3;
        @(negedge clk); chk("rt_masked", dec(), 32'b1100);
        nxt(); IF_ID_uses_rt = 1'b1;
        @(negedge clk); chk("rt_used", dec(), 32'b0001);
        nxt(); idle_in(); ID_EX_MEMRead = 1'b1;
        @(negedge clk); chk("r0_no_stall", dec(), 32'b1100);
        chk("rt_cnt", stall_cnt, 16'd2);

        // mult then mflo
        do_reset();
        ID_mdu_start = 1'b1; ID_mdu_div = 1'b0;
        @(negedge clk); chk("mult_issue", {mdu_issue, mdu_busy}, 2'b10);
        nxt(); idle_in(); ID_reads_hilo = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("mult_c%0d_mdu", i), {mdu_busy, mdu_done}, {1'b1, i == 4});
            chk($sformatf("mult_c%0d_dec", i), dec(), 32'b0001);
            nxt();
        end
        @(negedge clk);
        chk("mflo_go_mdu", {mdu_busy, mdu_done}, 2'b00);
        chk("mflo_go_dec", dec(), 32'b1100);
        chk("mult_cnt", stall_cnt, 16'd4);

        // div back-to-back
        do_reset();
        ID_mdu_start = 1'b1; ID_mdu_div = 1'b1;
        @(negedge clk); chk("div1_issue", mdu_issue, 1'b1);
        done_seen = 0;
        nxt();
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk($sformatf("div_c%0d", i), {mdu_issue, mdu_busy, PC_write}, 3'b010);
            if (mdu_done) done_seen = done_seen + (i == 32 ? 1 : 100);
            nxt();
        end
        @(negedge clk);
        chk("div_done_once", done_seen, 1);
        chk("div2_issue", {mdu_issue, mdu_busy}, 2'b10);
        chk("div_cnt", stall_cnt, 16'd32);
        nxt(); idle_in();
        @(negedge clk); chk("div2_running", mdu_busy, 1'b1);

        // branch beats load-use, flushed MDU op not issued
        do_reset();
        ID_EX_MEMRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
        EX_branch_taken = 1'b1; ID_mdu_start = 1'b1;
        @(negedge clk);
        chk("flush_dec", dec(), 32'b1111);
        chk("flush_no_issue", mdu_issue, 1'b0);
        nxt(); idle_in();
        @(negedge clk);
        chk("flush_cnt", stall_cnt, 16'd0);
        chk("flush_not_busy", mdu_busy, 1'b0);

        // reset in the 10th busy cycle of a div
        do_reset();
        ID_mdu_start = 1'b1; ID_mdu_div = 1'b1;
        nxt(); idle_in(); ID_reads_hilo = 1'b1;
        repeat (9) nxt();
        @(negedge clk);
        chk("rdiv_busy10", mdu_busy, 1'b1);
        chk("rdiv_cnt9", stall_cnt, 16'd9);
        #1 rst = 1'b1;
        nxt(); rst = 1'b0; idle_in();
        @(negedge clk);
        chk("rdiv_busy_clr", mdu_busy, 1'b0);
        chk("rdiv_cnt_clr", stall_cnt, 16'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdu_done || mdu_busy) done_seen++;
        end
        chk("rdiv_no_done", done_seen, 0);

        // saturation
        do_reset();
        ID_EX_MEMRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
        repeat (65541) @(posedge clk);
        #1 idle_in();
        @(negedge clk); chk("cnt_saturate", stall_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
